// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [2:0] {
        StBoot,
        StReq,
        StWait,
        StHold,
        StHalt
    } fetch_state_e;

    localparam logic [5:0]  OPC_HALT = 6'd63;
    localparam logic [5:0]  OPC_JAL  = 6'd25;
    localparam logic [31:0] PC_STEP  = 32'd4;

endpackage

// File: rtl/bit32a.sv
// Plain 32-bit adder; carry-out is dropped so results wrap modulo 2^32.
module bit32a (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/fetch_unit.sv
// Fetch/PC-sequencing stage: one outstanding instruction fetch, handed to execute,
// next PC chosen from the ALU redirect on acceptance.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,

    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,

    output logic [31:0] ins,
    output logic [31:0] pc,
    output logic        ins_valid,
    input  logic        ins_accept,
    input  logic        jump,
    input  logic [31:0] target,

    output logic [31:0] link_pc,
    output logic [31:0] retired,
    output logic        halted,
    output logic        misalign
);

    fetch_state_e state;
    logic [31:0]  pc_plus4;

    // One adder serves both the sequential next PC and the JAL link value.
    bit32a u_pc_add (
        .a   (pc),
        .b   (PC_STEP),
        .sum (pc_plus4)
    );

    assign link_pc   = pc_plus4;
    assign imem_addr = pc;
    assign imem_req  = (state == StReq);
    assign ins_valid = (state == StHold);
    assign halted    = (state == StHalt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= StBoot;
            pc       <= RESET_PC;
            ins      <= '0;
            retired  <= '0;
            misalign <= 1'b0;
        end else begin
            case (state)
                StBoot: state <= StReq;
                StReq: begin
                    if (imem_ready) begin
                        state <= StWait;
                    end
                end
                // Responses arriving in any other state are stale and dropped.
                StWait: begin
                    if (imem_rvalid) begin
                        ins   <= imem_rdata;
                        state <= StHold;
                    end
                end
                StHold: begin
                    if (ins_accept) begin
                        retired <= retired + 32'd1;
                        pc      <= jump ? {target[31:2], 2'b00} : pc_plus4;
                        if (jump && (target[1:0] != 2'b00)) begin
                            misalign <= 1'b1;
                        end
                        state <= (ins[31:26] == OPC_HALT) ? StHalt : StReq;
                    end
                end
                StHalt: state <= StHalt;
                default: state <= StBoot;
            endcase
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch and PC-sequencing stage sitting directly upstream of the ALU/execute stage. Holds the architectural PC, fetches one 32-bit instruction at a time from instruction memory over a req/ready + rvalid handshake, presents it with its PC to execute, and computes the next PC from the ALU's `jump`/`c` result on acceptance. Also provides the JAL link value, a retired-instruction counter, halt detection and a misaligned-target flag.

## Interface
- `RESET_PC`, default 32'h0000_0000, PC fetched first after reset (must be word-aligned).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  fetch request; address held stable until accepted.
- `imem_addr`  out  32  byte address of fetch (= `pc`).
- `imem_ready`  in  1  memory accepts request this cycle when `imem_req`=1.
- `imem_rvalid`  in  1  read data valid, never earlier than 1 cycle after acceptance.
- `imem_rdata`  in  32  instruction word.
- `ins`  out  32  instruction presented to execute.
- `pc`  out  32  PC of `ins`.
- `ins_valid`  out  1  `ins`/`pc` valid.
- `ins_accept`  in  1  execute consumes `ins` this cycle; `jump`/`target` sampled then.
- `jump`  in  1  ALU redirect request.
- `target`  in  32  ALU result `c`; next PC when `jump`=1.
- `link_pc`  out  32  `pc`+4 (JAL link value).
- `retired`  out  32  count of accepted instructions.
- `halted`  out  1  halt instruction retired.
- `misalign`  out  1  sticky: a redirect target had `target[1:0]`≠0.

## Operation
- States: BOOT, REQ, WAIT, HOLD, HALT. Reset state BOOT.
- BOOT: outputs idle; unconditionally → REQ next cycle.
- REQ: `imem_req`=1, `imem_addr`=`pc`. On `imem_ready` → WAIT.
- WAIT: on `imem_rvalid` capture `imem_rdata` into `ins` → HOLD.
- HOLD: `ins_valid`=1. On `ins_accept`: `retired`+1; next PC = `jump` ? {`target`[31:2],2'b00} : `pc`+4; if `jump` and `target[1:0]`≠0 set `misalign`. If `ins[31:26]`=6'd63 → HALT, else → REQ.
- HALT: `halted`=1, `imem_req`=0, `ins_valid`=0, PC frozen; exits only via `rst`.
- `imem_rvalid` outside WAIT is ignored (stale responses after reset dropped).
- `ins_accept` outside HOLD is ignored; `jump`/`target` ignored unless accepted.
- Arithmetic: `pc`+4 modulo 2^32 (0xFFFF_FFFC → 0x0000_0000); `retired` wraps 0xFFFF_FFFF → 0; `link_pc` = `pc`+4 combinational, same wrap.
- Reset (async, any state incl. mid-fetch): state=BOOT, `pc`=`imem_addr`=RESET_PC, `ins`=0, `ins_valid`=0, `imem_req`=0, `retired`=0, `halted`=0, `misalign`=0, `link_pc`=RESET_PC+4.

## Timing
- `imem_req` first high 1 cycle after `rst` deasserts (BOOT cycle).
- Request accepted at cycle T → earliest `imem_rvalid` T+1 → `ins_valid` T+2.
- Accept at cycle A → `imem_req` with new PC at A+1. Minimum 3 cycles/instruction.
- `ins`, `pc` stable for whole HOLD period; `imem_addr` stable while `imem_req`=1 and `imem_ready`=0.
- All outputs registered except `link_pc` and state-decoded `imem_req`/`ins_valid`/`halted`.

## Structure
- Package `fetch_pkg`: state enum, `OPC_HALT`=6'd63, `OPC_JAL`=6'd25, `PC_STEP`=32'd4.
- One sub-module: `bit32a` (existing 32-bit adder) instanced for `pc`+4; reused for `link_pc`.

## Test plan
- Reset, zero-wait memory (`imem_ready`=1, `rvalid` 1 cycle later), `ins_accept` tied 1, `jump`=0 -> fetch addresses 0,4,8,12; `retired`=4 after 4 accepts; 3 cycles apart.
- Accept at `pc`=0x10 with `jump`=1, `target`=0x40 -> next `imem_addr`=0x40, `link_pc` was 0x14; `misalign`=0.
- `jump`=1, `target`=0x43 -> next `imem_addr`=0x40, `misalign`=1 and stays 1.
- `imem_ready` low 5 cycles, `ins_accept` low 4 cycles in HOLD -> `imem_addr`, `ins`, `pc` stable; no duplicate fetch; `retired` +1 only.
- RESET_PC=0xFFFF_FFFC, accept `jump`=0 -> next fetch 0x0; opcode 6'd63 accepted -> `halted`=1, no further `imem_req`.
- `rst` asserted in WAIT, stale `imem_rvalid` 1 cycle after release -> ignored; first fetch at RESET_PC, `retired`=0.
